// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Holds the shared data RAM for the two matrix-multiplication cores. A single
// array port serves one request per clock. The arbiter chooses between the
// cores, the winning access completes at the sampling edge, and the grant,
// read-valid and read-data outputs are registered. Per-core completion is
// tracked in sticky flags that drive the host-visible all_done.
//
// Parameters:
//   ADDR_W  word address width (same as a core's data address)
//   DATA_W  data word width
//   DEPTH   implemented words (<= 2**ADDR_W); higher addresses read 0 and
//           drop writes, but are still granted
//
// Ports:
//   clock              rising-edge clock for all state
//   rst_n              synchronous active-low reset
//   req0/req1          request, held by the core until its grant
//   we0/we1            1 = write, 0 = read
//   addr0/addr1        word address
//   wdata0/wdata1      write data
//   gnt0/gnt1          one-cycle pulse: request performed at previous edge
//   rvalid0/rvalid1    one-cycle pulse alongside gnt for reads
//   rdata0/rdata1      read data, held until the next read on that port
//   done0/done1        core completion (pulse or level)
//   all_done           sticky, high once both cores have reported done
//
// Build option:
//   DMEM_FIXED_PRIORITY_EN  when defined, core 0 always wins ties and core 1
//                           may starve; otherwise ties alternate round-robin.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              done0,
  input  logic              done1,
  output logic              all_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              d0_q, d0_d, d1_q, d1_d;
  logic              all_done_q, all_done_d;

  // A port whose grant is showing this cycle is masked, so a request that is
  // being dropped in its grant cycle is never served twice.
  logic elig0, elig1;
  logic win0, win1;
  assign elig0 = req0 & ~gnt0_q;
  assign elig1 = req1 & ~gnt1_q;

`ifdef DMEM_FIXED_PRIORITY_EN
  assign win0 = elig0;
  assign win1 = elig1 & ~elig0;
`else
  // last_q remembers the most recent winner; on a tie the other port wins.
  // Reset value 1 lets core 0 take the first tie.
  logic last_q, last_d;

  always_comb begin
    win0   = elig0 & (~elig1 | last_q);
    win1   = elig1 & (~elig0 | ~last_q);
    last_d = last_q;
    if (win0) begin
      last_d = 1'b0;
    end else if (win1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Single array port: steer the winner's request onto it.
  logic              sel_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [IDX_W-1:0]  sel_idx;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  assign sel_valid = win0 | win1;
  assign sel_we    = win1 ? we1    : we0;
  assign sel_addr  = win1 ? addr1  : addr0;
  assign sel_wdata = win1 ? wdata1 : wdata0;
  assign sel_idx   = sel_addr[IDX_W-1:0];
  assign in_range  = {1'b0, sel_addr} < DEPTH_L;
  assign rd_word   = in_range ? mem_q[sel_idx] : '0;

  // RAM contents are not reset; reset only suppresses the write.
  always_ff @(posedge clock) begin
    if (rst_n && sel_valid && sel_we && in_range) begin
      mem_q[sel_idx] <= sel_wdata;
    end
  end

  always_comb begin
    gnt0_d     = win0;
    gnt1_d     = win1;
    rvalid0_d  = win0 & ~we0;
    rvalid1_d  = win1 & ~we1;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (win0 && !we0) begin
      rdata0_d = rd_word;
    end
    if (win1 && !we1) begin
      rdata1_d = rd_word;
    end
    d0_d       = d0_q | done0;
    d1_d       = d1_q | done1;
    all_done_d = d0_q & d1_q;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      d0_q       <= 1'b0;
      d1_q       <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      all_done_q <= all_done_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign all_done = all_done_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// Directed bench for dmem_responder (DEPTH = 128 so out-of-range addresses
// exist). Inputs change and outputs are sampled 1 time unit after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 128;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              done0, done1;
  logic              all_done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dmem_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .done0   (done0),
    .done1   (done1),
    .all_done(all_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_port0(input string tag, input logic g, input logic v, input logic [15:0] d);
    check({tag, ".gnt0"}, 32'(gnt0), 32'(g));
    check({tag, ".rvalid0"}, 32'(rvalid0), 32'(v));
    check({tag, ".rdata0"}, 32'(rdata0), 32'(d));
    $display("%0t %s: gnt0=%b rvalid0=%b rdata0=%h", $time, tag, gnt0, rvalid0, rdata0);
  endtask

  task automatic check_port1(input string tag, input logic g, input logic v, input logic [15:0] d);
    check({tag, ".gnt1"}, 32'(gnt1), 32'(g));
    check({tag, ".rvalid1"}, 32'(rvalid1), 32'(v));
    check({tag, ".rdata1"}, 32'(rdata1), 32'(d));
    $display("%0t %s: gnt1=%b rvalid1=%b rdata1=%h", $time, tag, gnt1, rvalid1, rdata1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    done0 = 1'b0; done1 = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;

    // Preload 0x20 = BEEF so the reset test has known prior contents.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'hBEEF;
    tick();
    check_port0("preload_wr", 1'b1, 1'b0, 16'h0000);
    req0 = 1'b0;
    tick();

    // Reset held 2 cycles with a pending write: no outputs, no write.
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_port0("reset", 1'b0, 1'b0, 16'h0000);
      check_port1("reset", 1'b0, 1'b0, 16'h0000);
      check("reset.all_done", 32'(all_done), 32'd0);
    end
    rst_n = 1'b1;
    req0 = 1'b0;
    tick();
    check_port0("post_reset_idle", 1'b0, 1'b0, 16'h0000);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    tick();
    check_port0("reset_rd_prior", 1'b1, 1'b1, 16'hBEEF);
    req0 = 1'b0;
    tick();
    check_port0("rdata_held", 1'b0, 1'b0, 16'hBEEF);

    // Single port: write 0x1234 to 0x05, then read it back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 16'h1234;
    tick();
    check_port0("single_wr", 1'b1, 1'b0, 16'hBEEF);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    tick();
    check_port0("single_rd", 1'b1, 1'b1, 16'h1234);
    req0 = 1'b0;
    tick();

    // Contention from reset: core 0 first, core 1 next edge.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    tick();
    check_port0("tie1_k1", 1'b1, 1'b1, 16'h1234);
    check_port1("tie1_k1", 1'b0, 1'b0, 16'h0000);
    req0 = 1'b0;
    tick();
    check_port0("tie1_k2", 1'b0, 1'b0, 16'h1234);
    check_port1("tie1_k2", 1'b1, 1'b1, 16'hBEEF);
    req1 = 1'b0;
    tick();
    // Lone core 0 access, then a second tie.
    req0 = 1'b1; addr0 = 8'h20;
    tick();
    check_port0("solo0", 1'b1, 1'b1, 16'hBEEF);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; addr0 = 8'h05;
    req1 = 1'b1; addr1 = 8'h05;
`ifdef DMEM_FIXED_PRIORITY_EN
    tick();
    check_port0("tie2_first", 1'b1, 1'b1, 16'h1234);
    check_port1("tie2_first", 1'b0, 1'b0, 16'hBEEF);
    req0 = 1'b0;
    tick();
    check_port1("tie2_second", 1'b1, 1'b1, 16'h1234);
    req1 = 1'b0;
`else
    tick();
    check_port1("tie2_first", 1'b1, 1'b1, 16'h1234);
    check_port0("tie2_first", 1'b0, 1'b0, 16'hBEEF);
    req1 = 1'b0;
    tick();
    check_port0("tie2_second", 1'b1, 1'b1, 16'h1234);
    req0 = 1'b0;
`endif
    tick();

    // Same-address write collision from reset: loser's data persists.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hAAAA;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'h5555;
    tick();
    check("coll_k1.gnt0", 32'(gnt0), 32'd1);
    check("coll_k1.gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    tick();
    check("coll_k2.gnt1", 32'(gnt1), 32'd1);
    check("coll_k2.rvalid1", 32'(rvalid1), 32'd0);
    req1 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    check_port0("coll_rd", 1'b1, 1'b1, 16'h5555);
    req0 = 1'b0;
    tick();

    // Out-of-range (DEPTH=128): read 0x90 gives 0, write 0x90 dropped.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    tick();
    check_port1("oor_pre", 1'b1, 1'b1, 16'h1234);
    req1 = 1'b0;
    tick();
    req1 = 1'b1; addr1 = 8'h90;
    tick();
    check_port1("oor_rd", 1'b1, 1'b1, 16'h0000);
    req1 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h90; wdata0 = 16'h7777;
    tick();
    check_port0("oor_wr", 1'b1, 1'b0, 16'h5555);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    check_port0("oor_alias", 1'b1, 1'b1, 16'h5555);
    req0 = 1'b0;
    tick();

    // Completion: done1 sampled at edge 3, done0 at edge 10 after reset.
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      done1 = (e == 3);
      done0 = (e == 10);
      tick();
      check($sformatf("all_done_e%0d", e), 32'(all_done), (e >= 11) ? 32'd1 : 32'd0);
      $display("%0t edge %0d: all_done=%b", $time, e, all_done);
    end
    done0 = 1'b0; done1 = 1'b0;
    tick();
    tick();
    check("all_done_held", 32'(all_done), 32'd1);
    // Still serving after all_done.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    tick();
    check_port1("after_done_rd", 1'b1, 1'b1, 16'h5555);
    req1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("all_done_reset", 32'(all_done), 32'd0);
    tick();
    tick();
    check("all_done_stays_low", 32'(all_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Dual-port data-memory responder for the matrix-multiplication cores. It owns the shared 16-bit data RAM and serves read/write requests from core 0 and core 1 through one single-ported array. A registered arbiter picks one request per cycle, and read data returns one cycle after sampling. The block also tracks per-core completion and raises a sticky `all_done` flag for the host.

## Interface
Parameters:
- `ADDR_W`, 8: address width, the same width as a core's data address.
- `DATA_W`, 16: data word width.
- `DEPTH`, 256: number of implemented words; must be ≤ 2^ADDR_W.

Ports:
- `clock`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req0` / `req1`  in  1  access request from core 0 / core 1; held until that port's grant.
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while the matching `req` is high.
- `addr0` / `addr1`  in  ADDR_W  word address; stable while `req` is high.
- `wdata0` / `wdata1`  in  DATA_W  write data; stable while `req` is high.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: the request was performed at the previous edge.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse, concurrent with `gnt` for reads only.
- `rdata0` / `rdata1`  out  DATA_W  read data, valid while `rvalid` is high and held until the next read on that port.
- `done0` / `done1`  in  1  core end-of-process indication; one-cycle pulse or level.
- `all_done`  out  1  sticky flag, high once both cores have signalled done.

## Operation
- Eligibility at each edge: port p is eligible if `req_p`=1 and `gnt_p`=0.
  - The grant mask forbids re-serving a request whose requester is dropping `req` in the grant cycle.
  - As a result, one port achieves at most one access per 2 cycles.
  - Two ports interleaving achieve one access per cycle.
- Arbitration: round-robin with a 1-bit `last` pointer.
  - If only one port is eligible, it wins.
  - If both are eligible, the port ≠ `last` wins.
  - `last` is updated to the winner.
- Winner access at the same edge:
  - Write: `mem[addr]` ← `wdata`.
  - Read: `rdata_p` ← `mem[addr]`.
  - `gnt_p` is registered 1. For reads, `rvalid_p` is also registered 1.
- The losing port keeps its request pending, with no timeout; the arbitration rule then serves it at the next edge.
- Out-of-range address (addr ≥ DEPTH):
  - The access is still granted.
  - A write is dropped.
  - A read returns 0 with `rvalid` asserted.
- Completion tracking:
  - Flags `d0` and `d1` are set when `done0` / `done1` is sampled high.
  - They are never cleared except by reset.
  - `all_done` is the registered value of `d0 & d1`.
  - Requests are still served after `all_done` is high.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `gnt*`=0, `rvalid*`=0, `rdata*`=0, `all_done`=0, `d0`=`d1`=0, `last`=1, so core 0 wins the first tie.
  - RAM contents are not reset.
  - No write occurs at a reset edge; requests pending at reset are discarded. Requesters must re-issue them after reset.
- Read latency: `req` sampled at edge k → `rdata`/`rvalid`/`gnt` valid during cycle k+1.
- Write: takes effect at edge k. A read of the same address granted at k+1 returns the new data.
- Simultaneous same-address writes from both ports: only the winner writes at edge k. The loser writes at k+1, so the loser's data persists.
- `done` sampled at edge k → `all_done` is high from cycle k+2 if the other flag was already set.

## Configuration
- Macro: `DMEM_FIXED_PRIORITY_EN`.
- Defined:
  - Core 0 always wins when both ports are eligible.
  - `last` is removed.
  - Core 1 may starve.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 2 cycles with `req0`=1 and `we0`=1.
  - Required: all outputs 0, no write performed, and a read of that address afterwards returns the prior contents.
- Single port:
  - Stimulus: core 0 writes 0x1234 to addr 0x05, then reads 0x05.
  - Required: `gnt0` one cycle after each request, `rvalid0`=1 only for the read, `rdata0`=0x1234.
- Contention:
  - Stimulus: both ports request reads in the same cycle from reset.
  - Required: `gnt0` at k+1, `gnt1` at k+2. On a second simultaneous pair, core 1 is served first, and core 1 wins alternate ties thereafter.
  - With `DMEM_FIXED_PRIORITY_EN`: core 0 is served first every time.
- Same-address collision:
  - Stimulus: both ports write addr 0x10 at once, with core 0 = 0xAAAA and core 1 = 0x5555, starting from reset.
  - Required: the final read of 0x10 returns 0x5555.
- Out-of-range access:
  - Stimulus: with `DEPTH`=128, read addr 0x90 and write addr 0x90.
  - Required: both granted, the read returns 0, and `mem[0x10]` is unchanged.
- Completion:
  - Stimulus: pulse `done1` at cycle 3 and `done0` at cycle 10.
  - Required: `all_done` low until cycle 12, then high and held; it clears only on `rst_n`=0.
